mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_ADDR_LEN, default 3, sets words per line: LINE_SIZE = 2^LINE_ADDR_LEN, 32-bit words.
REQ-002 Parameter ADDR_LEN, default 10, sets the line-address width presented to main memory.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pN_rd_req / pN_wr_req  input  1 each  read/write line request from requester N (N=0,1; port 0 = instruction cache, port 1 = data cache).
REQ-006 pN_addr  input  ADDR_LEN  line address of requester N.
REQ-007 pN_wr_line  input  LINE_SIZE*32  write line of requester N, word 0 in bits [31:0].
REQ-008 pN_rd_line  output  LINE_SIZE*32  read line returned to requester N.
REQ-009 pN_gnt  output  1  one-cycle completion strobe to requester N.
REQ-010 m_rd_req / m_wr_req  output  1 each  request to main memory.
REQ-011 m_addr  output  ADDR_LEN; m_wr_line  output  LINE_SIZE*32; m_rd_line  input  LINE_SIZE*32; m_gnt  input  1  memory completion strobe.
REQ-012 protocol_err  output  1  sticky flag: a port asserted rd_req and wr_req together.
REQ-013 pN_grant_cnt  output  16  saturating count of completed transactions per port.

Function
REQ-014 FSM states IDLE, BUSY0, BUSY1; the state is BUSYN while port N owns main memory.
REQ-015 In IDLE with no request pending on either port, state shall remain IDLE and m_rd_req = m_wr_req = 0.
REQ-016 In IDLE with exactly one port requesting, that port shall win at the clock edge; next state is BUSYN.
REQ-017 In IDLE with both ports requesting, the port not granted last shall win (round-robin); last_winner updates at win.
REQ-018 At win, the arbiter shall latch the winner's op, addr and wr_line; memory outputs are driven only from the latched copy while BUSYN.
REQ-019 If a port asserts rd_req and wr_req together, it shall be latched as a write and protocol_err set to 1 until reset.
REQ-020 In BUSYN: m_rd_req/m_wr_req = latched op, m_addr = latched addr, m_wr_line = latched line; all memory outputs are 0 outside BUSY states.
REQ-021 pN_gnt = m_gnt AND (state == BUSYN), combinational; it is never asserted for the non-owning port.
REQ-022 pN_rd_line = m_rd_line for both ports, combinational pass-through; valid for the owner in its pN_gnt cycle.
REQ-023 On m_gnt in BUSYN, next state shall be IDLE and pN_grant_cnt shall increment, holding at 16'hFFFF.
REQ-024 Latency: request sampled in IDLE at edge k -> m_*_req high from cycle k+1; after m_gnt, at least one IDLE cycle precedes the next memory request.
REQ-025 A requester deasserting its request while BUSYN shall not abort the transaction; it completes from the latched copy and pN_gnt still pulses.
REQ-026 Requests asserted during BUSY states are not queued; they are sampled only in IDLE, so requesters hold requests until pN_gnt.
REQ-027 m_gnt received in IDLE shall be ignored.

Reset
REQ-028 On rst: state IDLE, last_winner = 1 (port 0 wins the first contention), latched op/addr/line = 0, protocol_err = 0, both grant counters = 0, all memory-side request outputs 0.
REQ-029 rst asserted mid-transaction shall abandon it immediately; no pN_gnt is produced for it.

Verification
REQ-030 p0 read addr 0x005 alone; memory returns m_gnt after 50 cycles -> m_rd_req high from the next cycle with m_addr = 0x005; p0_gnt pulses once with p0_rd_line = m_rd_line; p0_grant_cnt = 1.
REQ-031 p0 read and p1 write requested in the same cycle after reset -> p0 served first, then IDLE, then p1 write; p1 remains un-granted until its own m_gnt.
REQ-032 Both ports request continuously for 6 transactions -> owners alternate 0,1,0,1,0,1; each grant counter = 3.
REQ-033 p1 write to 0x3FF with line pattern 0xA5A5_0000+i, then p1 drops wr_req during BUSY1 -> m_wr_line and m_addr remain unchanged until m_gnt; p1_gnt pulses.
REQ-034 p0 asserts rd_req and wr_req together -> m_wr_req = 1, m_rd_req = 0, protocol_err = 1 and stays 1 until rst.
REQ-035 rst pulsed during BUSY1 -> all outputs return to 0 immediately; a subsequent simultaneous request from both ports grants port 0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter sharing one line-wide main-memory port.
// Each winner's request is captured at grant so memory sees a stable copy for the whole transaction.
module mem_arbiter #(
   parameter int  LINE_ADDR_LEN = 3,
   parameter int  ADDR_LEN      = 10,
   localparam int LINE_W        = 32 * (2 ** LINE_ADDR_LEN)
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                p0_rd_req,
   input  logic                p0_wr_req,
   input  logic [ADDR_LEN-1:0] p0_addr,
   input  logic [LINE_W-1:0]   p0_wr_line,
   output logic [LINE_W-1:0]   p0_rd_line,
   output logic                p0_gnt,
   output logic [15:0]         p0_grant_cnt,

   input  logic                p1_rd_req,
   input  logic                p1_wr_req,
   input  logic [ADDR_LEN-1:0] p1_addr,
   input  logic [LINE_W-1:0]   p1_wr_line,
   output logic [LINE_W-1:0]   p1_rd_line,
   output logic                p1_gnt,
   output logic [15:0]         p1_grant_cnt,

   output logic                m_rd_req,
   output logic                m_wr_req,
   output logic [ADDR_LEN-1:0] m_addr,
   output logic [LINE_W-1:0]   m_wr_line,
   input  logic [LINE_W-1:0]   m_rd_line,
   input  logic                m_gnt,

   output logic                protocol_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic                last_winner, last_winner_nxt;
   logic                win_valid;
   logic                win_port;

   logic                lat_rd, lat_wr;
   logic [ADDR_LEN-1:0] lat_addr;
   logic [LINE_W-1:0]   lat_line;

   logic                req0, req1;
   logic                sel_rd, sel_wr;
   logic [ADDR_LEN-1:0] sel_addr;
   logic [LINE_W-1:0]   sel_line;
   logic                busy;
   logic                done0, done1;

   assign req0 = p0_rd_req | p0_wr_req;
   assign req1 = p1_rd_req | p1_wr_req;

   always_comb begin
      state_nxt       = state;
      last_winner_nxt = last_winner;
      win_valid       = 1'b0;
      win_port        = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               win_valid = 1'b1;
               win_port  = ~last_winner;
            end else if (req0) begin
               win_valid = 1'b1;
               win_port  = 1'b0;
            end else if (req1) begin
               win_valid = 1'b1;
               win_port  = 1'b1;
            end
            if (win_valid) begin
               state_nxt       = win_port ? BUSY1 : BUSY0;
               last_winner_nxt = win_port;
            end
         end
         BUSY0, BUSY1: begin
            if (m_gnt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Simultaneous rd+wr from a requester is treated as a write.
   assign sel_rd   = win_port ? p1_rd_req  : p0_rd_req;
   assign sel_wr   = win_port ? p1_wr_req  : p0_wr_req;
   assign sel_addr = win_port ? p1_addr    : p0_addr;
   assign sel_line = win_port ? p1_wr_line : p0_wr_line;

   assign busy  = (state == BUSY0) || (state == BUSY1);
   assign done0 = m_gnt && (state == BUSY0);
   assign done1 = m_gnt && (state == BUSY1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_winner  <= 1'b1;
         lat_rd       <= 1'b0;
         lat_wr       <= 1'b0;
         lat_addr     <= '0;
         lat_line     <= '0;
         protocol_err <= 1'b0;
         p0_grant_cnt <= '0;
         p1_grant_cnt <= '0;
      end else begin
         state       <= state_nxt;
         last_winner <= last_winner_nxt;
         if (win_valid) begin
            lat_wr   <= sel_wr;
            lat_rd   <= sel_rd & ~sel_wr;
            lat_addr <= sel_addr;
            lat_line <= sel_line;
         end
         if ((p0_rd_req && p0_wr_req) || (p1_rd_req && p1_wr_req))
            protocol_err <= 1'b1;
         if (done0 && (p0_grant_cnt != 16'hFFFF))
            p0_grant_cnt <= p0_grant_cnt + 16'd1;
         if (done1 && (p1_grant_cnt != 16'hFFFF))
            p1_grant_cnt <= p1_grant_cnt + 16'd1;
      end
   end

   // Memory side sees only the latched copy, and nothing outside a transaction.
   assign m_rd_req  = busy & lat_rd;
   assign m_wr_req  = busy & lat_wr;
   assign m_addr    = busy ? lat_addr : '0;
   assign m_wr_line = busy ? lat_line : '0;

   assign p0_gnt     = done0;
   assign p1_gnt     = done1;
   assign p0_rd_line = m_rd_line;
   assign p1_rd_line = m_rd_line;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table, directed corner sequences and randomized model check of mem_arbiter.
module tb_mem_arbiter;
   localparam int LAL = 3;
   localparam int AL  = 10;
   localparam int LW  = 32 << LAL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          p0_rd_req = 1'b0, p0_wr_req = 1'b0, p1_rd_req = 1'b0, p1_wr_req = 1'b0;
   logic [AL-1:0] p0_addr = '0, p1_addr = '0;
   logic [LW-1:0] p0_wr_line = '0, p1_wr_line = '0, m_rd_line = '0;
   logic          m_gnt = 1'b0;
   logic [LW-1:0] p0_rd_line, p1_rd_line, m_wr_line;
   logic          p0_gnt, p1_gnt, m_rd_req, m_wr_req, protocol_err;
   logic [AL-1:0] m_addr;
   logic [15:0]   p0_grant_cnt, p1_grant_cnt;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) dut (
      .clk(clk), .rst(rst),
      .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr), .p0_wr_line(p0_wr_line),
      .p0_rd_line(p0_rd_line), .p0_gnt(p0_gnt), .p0_grant_cnt(p0_grant_cnt),
      .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr), .p1_wr_line(p1_wr_line),
      .p1_rd_line(p1_rd_line), .p1_gnt(p1_gnt), .p1_grant_cnt(p1_grant_cnt),
      .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_addr(m_addr), .m_wr_line(m_wr_line),
      .m_rd_line(m_rd_line), .m_gnt(m_gnt), .protocol_err(protocol_err)
   );

   typedef struct {
      logic [4:0]  req;   // {r0,w0,r1,w1,m_gnt}
      logic [9:0]  a0;
      logic [9:0]  a1;
      logic [4:0]  eo;    // {m_rd,m_wr,g0,g1,perr}
      logic [9:0]  ea;
      logic [15:0] c0;
      logic [15:0] c1;
   } vec_t;

   vec_t vt[11];

   // reference model state
   int            mo;
   int            mlast;
   logic          mperr;
   logic [15:0]   mcnt0, mcnt1;
   logic          mt_rd, mt_wr;
   logic [AL-1:0] mt_addr;
   logic [LW-1:0] mt_line;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p0_rd_req = 1'b0; p0_wr_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b0; m_gnt = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [63:0] ctl_vec();
      return 64'({m_rd_req, m_wr_req, p0_gnt, p1_gnt, protocol_err, m_addr, p0_grant_cnt, p1_grant_cnt});
   endfunction

   initial begin
      logic [LW-1:0] line_a, pat;
      logic          ex_rd, ex_wr, ex_g0, ex_g1;
      logic [AL-1:0] ex_addr;
      logic [LW-1:0] ex_line;
      int            w;
      int            op;

      vt[0]  = '{5'b00001, 10'h005, 10'h3FF, 5'b00000, 10'h000, 16'd0, 16'd0};
      vt[1]  = '{5'b10010, 10'h005, 10'h3FF, 5'b00000, 10'h000, 16'd0, 16'd0};
      vt[2]  = '{5'b10010, 10'h005, 10'h3FF, 5'b10000, 10'h005, 16'd0, 16'd0};
      vt[3]  = '{5'b10011, 10'h005, 10'h3FF, 5'b10100, 10'h005, 16'd0, 16'd0};
      vt[4]  = '{5'b00011, 10'h005, 10'h3FF, 5'b00000, 10'h000, 16'd1, 16'd0};
      vt[5]  = '{5'b00000, 10'h005, 10'h3FF, 5'b01000, 10'h3FF, 16'd1, 16'd0};
      vt[6]  = '{5'b00001, 10'h005, 10'h3FF, 5'b01010, 10'h3FF, 16'd1, 16'd0};
      vt[7]  = '{5'b11000, 10'h012, 10'h3FF, 5'b00000, 10'h000, 16'd1, 16'd1};
      vt[8]  = '{5'b00000, 10'h012, 10'h3FF, 5'b01001, 10'h012, 16'd1, 16'd1};
      vt[9]  = '{5'b00001, 10'h012, 10'h3FF, 5'b01101, 10'h012, 16'd1, 16'd1};
      vt[10] = '{5'b00000, 10'h012, 10'h3FF, 5'b00001, 10'h000, 16'd2, 16'd1};

      // reset state
      tick();
      #1;
      chk("reset_ctl", LW'(ctl_vec()), '0);
      chk("reset_wline", m_wr_line, '0);
      rst = 1'b0;
      tick();

      // vector table
      p0_wr_line = rand_line();
      p1_wr_line = rand_line();
      for (int i = 0; i < 11; i++) begin
         {p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req, m_gnt} = vt[i].req;
         p0_addr = vt[i].a0;
         p1_addr = vt[i].a1;
         #2;
         chk($sformatf("vec%0d", i), LW'(ctl_vec()),
             LW'(64'({vt[i].eo[4:3], vt[i].eo[2:0], vt[i].ea, vt[i].c0, vt[i].c1})));
         tick();
      end

      // protocol_err is sticky until reset
      do_reset();
      #1;
      chk("perr_cleared", LW'(protocol_err), '0);

      // long-latency single read
      p0_rd_req = 1'b1; p0_addr = 10'h005;
      tick();
      for (int i = 0; i < 50; i++) begin
         #1;
         chk("lat_wait", LW'({m_rd_req, m_wr_req, p0_gnt, m_addr}), LW'({3'b100, 10'h005}));
         tick();
      end
      line_a = rand_line();
      m_rd_line = line_a; m_gnt = 1'b1;
      #2;
      chk("lat_gnt", LW'({p0_gnt, p1_gnt}), LW'(2'b10));
      chk("lat_rline", p0_rd_line, line_a);
      tick();
      p0_rd_req = 1'b0; m_gnt = 1'b0;
      #2;
      chk("lat_after", LW'(ctl_vec()), LW'(64'({5'b00000, 10'h000, 16'd1, 16'd0})));

      // write line held from latch after requester drops
      do_reset();
      for (int i = 0; i < LW / 32; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + i;
      p1_wr_req = 1'b1; p1_addr = 10'h3FF; p1_wr_line = pat;
      tick();
      p1_wr_req = 1'b0; p1_addr = 10'h000; p1_wr_line = rand_line();
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("hold_line", m_wr_line, pat);
         chk("hold_addr", LW'({m_wr_req, m_rd_req, m_addr}), LW'({2'b10, 10'h3FF}));
         tick();
      end
      m_gnt = 1'b1;
      #2;
      chk("hold_gnt", LW'({p0_gnt, p1_gnt}), LW'(2'b01));
      tick();
      m_gnt = 1'b0;
      #2;
      chk("hold_cnt", LW'({p0_grant_cnt, p1_grant_cnt}), LW'({16'd0, 16'd1}));

      // continuous contention alternates owners
      do_reset();
      p0_rd_req = 1'b1; p1_wr_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         m_gnt = 1'b1;
         #2;
         chk($sformatf("rr_owner%0d", i), LW'({p0_gnt, p1_gnt}), (i % 2 == 0) ? LW'(2'b10) : LW'(2'b01));
         tick();
         m_gnt = 1'b0;
         #2;
         chk("rr_idle_gap", LW'({m_rd_req, m_wr_req}), '0);
      end
      chk("rr_counts", LW'({p0_grant_cnt, p1_grant_cnt}), LW'({16'd3, 16'd3}));

      // reset mid-transaction
      do_reset();
      p1_rd_req = 1'b1; p1_addr = 10'h0AA;
      tick();
      #2;
      chk("rst_busy", LW'({m_rd_req, m_addr}), LW'({1'b1, 10'h0AA}));
      rst = 1'b1; m_gnt = 1'b1;
      #1;
      chk("rst_ctl", LW'({m_rd_req, m_wr_req, m_addr, p0_gnt, p1_gnt}), '0);
      chk("rst_wline", m_wr_line, '0);
      tick();
      rst = 1'b0; m_gnt = 1'b0;
      p0_rd_req = 1'b1; p0_addr = 10'h055;
      tick();
      #2;
      chk("rst_first", LW'({m_rd_req, m_wr_req, m_addr}), LW'({2'b10, 10'h055}));
      m_gnt = 1'b1;
      #1;
      chk("rst_first_gnt", LW'({p0_gnt, p1_gnt}), LW'(2'b10));
      tick();

      // randomized run against the reference model
      do_reset();
      mo = -1; mlast = 1; mperr = 1'b0; mcnt0 = '0; mcnt1 = '0;
      mt_rd = 1'b0; mt_wr = 1'b0; mt_addr = '0; mt_line = '0;
      for (int c = 0; c < 3000; c++) begin
         op = $urandom_range(0, 31);
         p0_rd_req = (op >= 10 && op <= 19) || op == 31;
         p0_wr_req = (op >= 20 && op <= 30) || op == 31;
         op = $urandom_range(0, 31);
         p1_rd_req = (op >= 10 && op <= 19) || op == 31;
         p1_wr_req = (op >= 20 && op <= 30) || op == 31;
         p0_addr = AL'($urandom); p1_addr = AL'($urandom);
         p0_wr_line = rand_line(); p1_wr_line = rand_line(); m_rd_line = rand_line();
         m_gnt = ($urandom_range(0, 9) < 3);
         #2;
         if (mo >= 0) begin
            ex_rd = mt_rd; ex_wr = mt_wr; ex_addr = mt_addr; ex_line = mt_line;
         end else begin
            ex_rd = 1'b0; ex_wr = 1'b0; ex_addr = '0; ex_line = '0;
         end
         ex_g0 = (mo == 0) && m_gnt;
         ex_g1 = (mo == 1) && m_gnt;
         chk("rnd_ctl", LW'(ctl_vec()), LW'(64'({ex_rd, ex_wr, ex_g0, ex_g1, mperr, ex_addr, mcnt0, mcnt1})));
         chk("rnd_wline", m_wr_line, ex_line);
         chk("rnd_rline", LW'({p0_rd_line == m_rd_line, p1_rd_line == m_rd_line}), LW'(2'b11));

         if ((p0_rd_req && p0_wr_req) || (p1_rd_req && p1_wr_req)) mperr = 1'b1;
         if (mo >= 0) begin
            if (m_gnt) begin
               if (mo == 0 && mcnt0 != 16'hFFFF) mcnt0 = mcnt0 + 16'd1;
               if (mo == 1 && mcnt1 != 16'hFFFF) mcnt1 = mcnt1 + 16'd1;
               mo = -1;
            end
         end else begin
            w = -1;
            if ((p0_rd_req || p0_wr_req) && (p1_rd_req || p1_wr_req)) w = 1 - mlast;
            else if (p0_rd_req || p0_wr_req) w = 0;
            else if (p1_rd_req || p1_wr_req) w = 1;
            if (w >= 0) begin
               mo = w; mlast = w;
               mt_wr   = (w == 1) ? p1_wr_req : p0_wr_req;
               mt_rd   = ((w == 1) ? p1_rd_req : p0_rd_req) && !mt_wr;
               mt_addr = (w == 1) ? p1_addr : p0_addr;
               mt_line = (w == 1) ? p1_wr_line : p0_wr_line;
            end
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
